// File: rtl/fb_bram_ctrl.sv
// Frame-buffer BRAM controller: port A is shared by the host requester and a clear engine,
// and port B is a free-running display fetch channel.
module fb_bram_ctrl #(
   parameter int unsigned          RAM_WIDTH = 12,
   parameter int unsigned          RAM_DEPTH = 1024,
   parameter logic [RAM_WIDTH-1:0] CLEAR_VAL = '0,
   localparam int unsigned         ADDR_W    = $clog2(RAM_DEPTH-1)
) (
   input  logic                 clk,
   input  logic                 rstn,
   input  logic                 host_valid,
   output logic                 host_ready,
   input  logic                 host_we,
   input  logic [ADDR_W-1:0]    host_addr,
   input  logic [RAM_WIDTH-1:0] host_wdata,
   output logic                 host_rvalid,
   output logic [RAM_WIDTH-1:0] host_rdata,
   input  logic                 clear_req,
   output logic                 clear_busy,
   output logic                 clear_done,
   input  logic                 disp_en,
   input  logic [ADDR_W-1:0]    disp_addr,
   output logic                 disp_valid,
   output logic [RAM_WIDTH-1:0] disp_data,
   output logic                 bram_ena,
   output logic                 bram_wea,
   output logic [ADDR_W-1:0]    bram_addra,
   output logic [RAM_WIDTH-1:0] bram_dina,
   output logic                 bram_enb,
   output logic                 bram_web,
   output logic [ADDR_W-1:0]    bram_addrb,
   output logic [RAM_WIDTH-1:0] bram_dinb,
   input  logic [RAM_WIDTH-1:0] bram_douta,
   input  logic [RAM_WIDTH-1:0] bram_doutb
);

   localparam logic [0:0]        ST_IDLE   = 1'b0;
   localparam logic [0:0]        ST_CLEAR  = 1'b1;
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(RAM_DEPTH - 1);

   logic [0:0]        state_q, state_d;
   logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
   logic              host_rvalid_q, host_rvalid_d;
   logic              disp_valid_q, disp_valid_d;
   logic              clear_done_q, clear_done_d;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q       <= ST_IDLE;
         clr_cnt_q     <= '0;
         host_rvalid_q <= 1'b0;
         disp_valid_q  <= 1'b0;
         clear_done_q  <= 1'b0;
      end else begin
         state_q       <= state_d;
         clr_cnt_q     <= clr_cnt_d;
         host_rvalid_q <= host_rvalid_d;
         disp_valid_q  <= disp_valid_d;
         clear_done_q  <= clear_done_d;
      end
   end

   // Port A arbitration: the clear engine owns the port for RAM_DEPTH consecutive cycles.
   always_comb begin
      state_d       = state_q;
      clr_cnt_d     = clr_cnt_q;
      clear_done_d  = 1'b0;
      host_rvalid_d = 1'b0;
      bram_ena      = 1'b0;
      bram_wea      = 1'b0;
      bram_addra    = host_addr;
      bram_dina     = host_wdata;
      case (state_q)
         ST_IDLE: begin
            bram_ena      = host_valid;
            bram_wea      = host_valid & host_we;
            host_rvalid_d = host_valid & ~host_we;
            if (clear_req) begin
               state_d   = ST_CLEAR;
               clr_cnt_d = '0;
            end
         end
         ST_CLEAR: begin
            bram_ena   = 1'b1;
            bram_wea   = 1'b1;
            bram_addra = clr_cnt_q;
            bram_dina  = CLEAR_VAL;
            if (clr_cnt_q == LAST_ADDR) begin
               state_d      = ST_IDLE;
               clr_cnt_d    = '0;
               clear_done_d = 1'b1;
            end else begin
               clr_cnt_d = clr_cnt_q + ADDR_W'(1);
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Display channel never stalls and never writes.
   always_comb begin
      disp_valid_d = disp_en;
      bram_enb     = disp_en;
      bram_web     = 1'b0;
      bram_addrb   = disp_addr;
      bram_dinb    = '0;
   end

   assign host_ready  = (state_q == ST_IDLE);
   assign clear_busy  = (state_q == ST_CLEAR);
   assign clear_done  = clear_done_q;
   assign host_rvalid = host_rvalid_q;
   assign host_rdata  = bram_douta;
   assign disp_valid  = disp_valid_q;
   assign disp_data   = bram_doutb;

endmodule

// File: tb/tb_fb_bram_ctrl.sv
// Bench for fb_bram_ctrl: read-first dual-port BRAM model plus an array reference of
// the frame-buffer contents, exercised with directed clear scenarios and random traffic.
module tb_fb_bram_ctrl;

   localparam int unsigned W = 12;
   localparam int unsigned D = 16;
   localparam int unsigned A = 4;
   localparam logic [W-1:0] CV = 12'hABC;

   logic         clk = 1'b0;
   logic         rstn;
   logic         host_valid, host_ready, host_we, host_rvalid;
   logic [A-1:0] host_addr;
   logic [W-1:0] host_wdata, host_rdata;
   logic         clear_req, clear_busy, clear_done;
   logic         disp_en, disp_valid;
   logic [A-1:0] disp_addr;
   logic [W-1:0] disp_data;
   logic         bram_ena, bram_wea, bram_enb, bram_web;
   logic [A-1:0] bram_addra, bram_addrb;
   logic [W-1:0] bram_dina, bram_dinb, bram_douta, bram_doutb;

   logic [W-1:0] mem     [D];
   logic [W-1:0] ref_mem [D];
   int total = 0;
   int bad   = 0;

   fb_bram_ctrl #(.RAM_WIDTH(W), .RAM_DEPTH(D), .CLEAR_VAL(CV)) dut (
      .clk(clk), .rstn(rstn),
      .host_valid(host_valid), .host_ready(host_ready), .host_we(host_we),
      .host_addr(host_addr), .host_wdata(host_wdata),
      .host_rvalid(host_rvalid), .host_rdata(host_rdata),
      .clear_req(clear_req), .clear_busy(clear_busy), .clear_done(clear_done),
      .disp_en(disp_en), .disp_addr(disp_addr), .disp_valid(disp_valid), .disp_data(disp_data),
      .bram_ena(bram_ena), .bram_wea(bram_wea), .bram_addra(bram_addra), .bram_dina(bram_dina),
      .bram_enb(bram_enb), .bram_web(bram_web), .bram_addrb(bram_addrb), .bram_dinb(bram_dinb),
      .bram_douta(bram_douta), .bram_doutb(bram_doutb)
   );

   always #5 clk = ~clk;

   // Read-first BRAM: both ports see the pre-edge contents.
   always @(posedge clk) begin
      if (bram_ena) begin
         bram_douta <= mem[bram_addra];
         if (bram_wea) mem[bram_addra] <= bram_dina;
      end
      if (bram_enb) begin
         bram_doutb <= mem[bram_addrb];
         if (bram_web) mem[bram_addrb] <= bram_dinb;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      total++;
      if (obs !== exp_v) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
      end
   endtask

   // One IDLE-state cycle with optional host op and display fetch; entered at posedge+1.
   task automatic step_op(input logic hv, input logic we, input logic [A-1:0] a,
                          input logic [W-1:0] d, input logic de, input logic [A-1:0] da);
      logic [W-1:0] exp_r, exp_d;
      host_valid = hv; host_we = we; host_addr = a; host_wdata = d;
      disp_en = de; disp_addr = da;
      #1;
      chk("idle_ready", 32'(host_ready), 32'd1);
      chk("host_ena", 32'(bram_ena), 32'(hv));
      exp_r = ref_mem[a];
      exp_d = ref_mem[da];
      if (hv && we) ref_mem[a] = d;
      @(posedge clk); #1;
      host_valid = 1'b0; disp_en = 1'b0;
      chk("rvalid", 32'(host_rvalid), 32'(hv && !we));
      if (hv && !we) chk("rdata", 32'(host_rdata), 32'(exp_r));
      chk("disp_valid", 32'(disp_valid), 32'(de));
      if (de) chk("disp_data", 32'(disp_data), 32'(exp_d));
   endtask

   task automatic read_all();
      for (int a = 0; a < int'(D); a++) step_op(1'b1, 1'b0, A'(a), '0, 1'b1, A'(a));
   endtask

   task automatic random_ops(input int n);
      logic [A-1:0] a;
      for (int i = 0; i < n; i++) begin
         a = A'($urandom);
         step_op(1'($urandom_range(0, 3) != 0), 1'($urandom), a, W'($urandom),
                 1'($urandom), ($urandom_range(0, 1) != 0) ? a : A'($urandom));
      end
   endtask

   // Clear sequence; optional same-cycle host write to addr 3, host read held through the
   // clear, or a reset injected when the clear address reaches abort_at.
   task automatic run_clear(input bit host_same, input bit hold, input logic [A-1:0] ha,
                            input int abort_at);
      logic [W-1:0] pre7, hd;
      step_op(1'b1, 1'b1, A'(7), 12'h5A5, 1'b0, '0);
      hd = W'($urandom_range(0, 12'hAB0));
      clear_req = 1'b1;
      if (host_same) begin
         host_valid = 1'b1; host_we = 1'b1; host_addr = A'(3); host_wdata = hd;
      end
      #1;
      chk("clr_start_ready", 32'(host_ready), 32'd1);
      if (host_same) begin
         chk("same_ena", 32'(bram_ena), 32'd1);
         chk("same_wea", 32'(bram_wea), 32'd1);
         chk("same_addr", 32'(bram_addra), 32'd3);
         ref_mem[3] = hd;
      end
      pre7 = ref_mem[7];
      @(posedge clk); #1;
      clear_req = 1'b0; host_valid = hold; host_we = 1'b0; host_addr = ha;
      for (int i = 0; i < int'(D); i++) begin
         if (i == abort_at) begin
            rstn = 1'b0;
            #1;
            chk("rst_busy", 32'(clear_busy), 32'd0);
            chk("rst_done", 32'(clear_done), 32'd0);
            chk("rst_rvalid", 32'(host_rvalid), 32'd0);
            chk("rst_dvalid", 32'(disp_valid), 32'd0);
            chk("rst_ena", 32'(bram_ena), 32'd0);
            for (int j = 0; j < 3; j++) begin
               @(posedge clk); #1;
               chk("rst_no_done", 32'(clear_done), 32'd0);
            end
            rstn = 1'b1;
            @(posedge clk); #1;
            chk("post_rst_ready", 32'(host_ready), 32'd1);
            chk("post_rst_done", 32'(clear_done), 32'd0);
            for (int k = 0; k < abort_at; k++) ref_mem[k] = CV;
            return;
         end
         #1;
         chk("clr_busy", 32'(clear_busy), 32'd1);
         chk("clr_ready", 32'(host_ready), 32'd0);
         chk("clr_ena", 32'(bram_ena), 32'd1);
         chk("clr_wea", 32'(bram_wea), 32'd1);
         chk("clr_addra", 32'(bram_addra), 32'(i));
         chk("clr_dina", 32'(bram_dina), 32'(CV));
         chk("clr_no_done", 32'(clear_done), 32'd0);
         if (i == 8 && abort_at < 0) begin
            chk("collide_dvalid", 32'(disp_valid), 32'd1);
            chk("collide_ddata", 32'(disp_data), 32'(pre7));
            disp_en = 1'b0;
         end
         clear_req = (i == 5);
         if (i == 7 && abort_at < 0) begin
            disp_en = 1'b1; disp_addr = A'(7);
         end
         @(posedge clk); #1;
      end
      clear_req = 1'b0;
      #1;
      chk("end_busy", 32'(clear_busy), 32'd0);
      chk("end_done", 32'(clear_done), 32'd1);
      chk("end_ready", 32'(host_ready), 32'd1);
      if (hold) begin
         chk("hold_ena", 32'(bram_ena), 32'd1);
         chk("hold_addr", 32'(bram_addra), 32'(ha));
      end
      for (int k = 0; k < int'(D); k++) ref_mem[k] = CV;
      @(posedge clk); #1;
      host_valid = 1'b0;
      chk("done_pulse_end", 32'(clear_done), 32'd0);
      chk("no_restart", 32'(clear_busy), 32'd0);
      if (hold) begin
         chk("hold_rvalid", 32'(host_rvalid), 32'd1);
         chk("hold_rdata", 32'(host_rdata), 32'(CV));
      end
   endtask

   initial begin
      rstn = 1'b1;
      host_valid = 1'b0; host_we = 1'b0; host_addr = '0; host_wdata = '0;
      clear_req = 1'b0; disp_en = 1'b0; disp_addr = '0;
      #2 rstn = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_rvalid", 32'(host_rvalid), 32'd0);
      chk("reset_dvalid", 32'(disp_valid), 32'd0);
      chk("reset_busy", 32'(clear_busy), 32'd0);
      chk("reset_done", 32'(clear_done), 32'd0);
      rstn = 1'b1;
      @(posedge clk); #1;
      chk("reset_ready", 32'(host_ready), 32'd1);

      for (int a = 0; a < int'(D); a++) step_op(1'b1, 1'b1, A'(a), W'($urandom), 1'b0, '0);
      step_op(1'b1, 1'b1, A'(5), 12'h123, 1'b0, '0);
      step_op(1'b1, 1'b0, A'(5), '0, 1'b0, '0);
      step_op(1'b0, 1'b0, '0, '0, 1'b0, '0);
      random_ops(120);
      run_clear(1'b0, 1'b0, '0, -1);
      read_all();
      random_ops(40);
      run_clear(1'b0, 1'b1, A'(9), -1);
      random_ops(60);
      run_clear(1'b1, 1'b0, '0, -1);
      read_all();
      random_ops(60);
      for (int a = 0; a < int'(D); a++) step_op(1'b1, 1'b1, A'(a), W'(a + 1), 1'b0, '0);
      run_clear(1'b0, 1'b0, '0, 8);
      read_all();
      random_ops(60);
      read_all();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
